prism_seq: RTL

Load-and-run sequencer for the PRISM controller's debug port. Software queues (address, data) configuration writes into a small FIFO, then issues `start`. The block then:

- drains the queue onto the PRISM debug write port, yielding to direct bus writes;
- pulses the PRISM debug reset;
- enables the FSM and waits for halt or watchdog timeout;
- raises a level interrupt when finished.

It sits between the TinyQV peripheral wrapper and the `prism` instance. It owns `debug_reset`, `fsm_enable` and the debug write mux.

---
 rtl/prism_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/prism_seq.sv
// rtl/prism_seq.sv - PRISM debug-port load-and-run sequencer with command FIFO
// Optional watchdog built when PRISM_SEQ_WATCHDOG_EN is defined.
module prism_seq #(
  parameter int          DEPTH      = 4,
  parameter int          RST_CYCLES = 2,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        start,
  input  logic        abort,
  input  logic        irq_clr,
  input  logic        bus_wr,
  input  logic [5:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        prism_halt,
  output logic        dbg_wr,
  output logic [5:0]  dbg_addr,
  output logic [31:0] dbg_wdata,
  output logic        debug_reset,
  output logic        fsm_enable,
  output logic        busy,
  output logic        timed_out,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RESET = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [37:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          timeout_hit;
  logic          done_entry;
  logic          irq_q;
  logic [3:0]    rst_cnt;

  // Abort discards a same-cycle push; bus writes stall the pop and keep the head.
  assign push = cmd_valid && ready_q && !abort;
  assign pop  = (state == S_LOAD) && (count != '0) && !bus_wr;

  always_comb begin
    count_nxt = count;
    if (abort) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      count   <= count_nxt;
      ready_q <= (count_nxt != CW'(DEPTH));
      if (abort) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_addr, cmd_data};
  end

  assign cmd_ready = ready_q;

  always_comb begin
    dbg_wr    = 1'b0;
    dbg_addr  = '0;
    dbg_wdata = '0;
    if (bus_wr) begin
      dbg_wr    = 1'b1;
      dbg_addr  = bus_addr;
      dbg_wdata = bus_wdata;
    end else if (pop) begin
      dbg_wr    = 1'b1;
      dbg_addr  = mem[rd_ptr][37:32];
      dbg_wdata = mem[rd_ptr][31:0];
    end
  end

  assign done_entry = (state == S_RUN) && !abort && (prism_halt || timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rst_cnt <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_LOAD;
        S_LOAD: begin
          if (count == '0) begin
            state   <= S_RESET;
            rst_cnt <= 4'(RST_CYCLES);
          end
        end
        S_RESET: begin
          if (rst_cnt == 4'd1) state <= S_RUN;
          else                 rst_cnt <= rst_cnt - 4'd1;
        end
        S_RUN:   if (prism_halt || timeout_hit) state <= S_DONE;
        S_DONE:  if (start) state <= S_LOAD;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Entering DONE wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          irq_q <= 1'b0;
    else if (done_entry) irq_q <= 1'b1;
    else if (irq_clr)    irq_q <= 1'b0;
  end

`ifdef PRISM_SEQ_WATCHDOG_EN
  logic [15:0] wd;
  logic        timed_out_q;

  assign timeout_hit = (wd == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd          <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (state == S_RESET && rst_cnt == 4'd1) wd <= '0;
      else if (state == S_RUN)                 wd <= wd + 16'd1;
      if (abort)                          timed_out_q <= 1'b0;
      else if (done_entry)                timed_out_q <= !prism_halt;
      else if (state == S_DONE && start)  timed_out_q <= 1'b0;
    end
  end

  assign timed_out = timed_out_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  assign irq         = irq_q;
  assign busy        = (state == S_LOAD) || (state == S_RESET) || (state == S_RUN);
  assign debug_reset = (state == S_RESET);
  assign fsm_enable  = (state == S_RUN);

endmodule
